// File: rtl/axi_lite_slave_ctrl.sv
// AXI4-Lite slave front-end that bridges to a valid/ready native register bus.
// Write and read paths run independently. Each path decodes an address window
// and bounds every backend access with a cycle timeout.
module axi_lite_slave_ctrl #(
    parameter int unsigned        ADDR_W  = 32,
    parameter int unsigned        DATA_W  = 32,
    parameter logic [ADDR_W-1:0]  ADDR_LO = '0,
    parameter logic [ADDR_W-1:0]  ADDR_HI = 'hFFF,
    parameter int unsigned        TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   i_s_awaddr,
    input  logic                i_s_awvalid,
    output logic                o_s_awready,
    input  logic [DATA_W-1:0]   i_s_wdata,
    input  logic [DATA_W/8-1:0] i_s_wstrb,
    input  logic                i_s_wvalid,
    output logic                o_s_wready,
    output logic [1:0]          o_s_bresp,
    output logic                o_s_bvalid,
    input  logic                i_s_bready,
    input  logic [ADDR_W-1:0]   i_s_araddr,
    input  logic                i_s_arvalid,
    output logic                o_s_arready,
    output logic [DATA_W-1:0]   o_s_rdata,
    output logic [1:0]          o_s_rresp,
    output logic                o_s_rvalid,
    input  logic                i_s_rready,
    output logic [ADDR_W-1:0]   o_wr_addr,
    output logic [DATA_W-1:0]   o_wr_data,
    output logic [DATA_W/8-1:0] o_wr_strb,
    output logic                o_wr_valid,
    input  logic                i_wr_ready,
    input  logic [1:0]          i_wr_resp,
    output logic [ADDR_W-1:0]   o_rd_addr,
    output logic                o_rd_valid,
    input  logic                i_rd_ready,
    input  logic [DATA_W-1:0]   i_rd_data,
    input  logic [1:0]          i_rd_resp
);

    localparam int unsigned       STRB_W     = DATA_W / 8;
    localparam int unsigned       CNT_W      = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(STRB_W - 1);
    localparam logic [ADDR_W-1:0] SPAN       = ADDR_HI - ADDR_LO;
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [1:0]        RESP_SLVERR = 2'b10;
    localparam logic [1:0]        RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_COLLECT, W_REQ, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_REQ, R_RESP} rstate_t;

    // Single unsigned compare: offsets below ADDR_LO wrap to large values.
    function automatic logic f_in_window(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] off;
        off = a - ADDR_LO;
        return off <= SPAN;
    endfunction

    wstate_t             r_wstate;
    logic                r_awready, r_wready, r_bvalid, r_wr_valid;
    logic [1:0]          r_bresp;
    logic [ADDR_W-1:0]   r_awaddr;
    logic [DATA_W-1:0]   r_wdata;
    logic [STRB_W-1:0]   r_wstrb;
    logic [CNT_W-1:0]    r_wcnt;

    rstate_t             r_rstate;
    logic                r_arready, r_rvalid, r_rd_valid;
    logic [1:0]          r_rresp;
    logic [ADDR_W-1:0]   r_araddr;
    logic [DATA_W-1:0]   r_rdata;
    logic [CNT_W-1:0]    r_rcnt;

    // Ready registers are only set while collecting, so a handshake implies W_COLLECT.
    logic              w_aw_hs, w_w_hs, w_aw_have, w_w_have;
    logic [ADDR_W-1:0] w_awaddr_cur;

    assign w_aw_hs      = i_s_awvalid & r_awready;
    assign w_w_hs       = i_s_wvalid & r_wready;
    assign w_aw_have    = ~r_awready | w_aw_hs;
    assign w_w_have     = ~r_wready | w_w_hs;
    assign w_awaddr_cur = w_aw_hs ? i_s_awaddr : r_awaddr;

    // Write path: collect AW/W, issue backend request, return B response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wstate   <= W_COLLECT;
            r_awready  <= 1'b1;
            r_wready   <= 1'b1;
            r_bvalid   <= 1'b0;
            r_bresp    <= 2'b00;
            r_wr_valid <= 1'b0;
            r_awaddr   <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_wcnt     <= '0;
        end else begin
            case (r_wstate)
                W_COLLECT: begin
                    if (w_aw_hs) begin
                        r_awaddr  <= i_s_awaddr;
                        r_awready <= 1'b0;
                    end
                    if (w_w_hs) begin
                        r_wdata  <= i_s_wdata;
                        r_wstrb  <= i_s_wstrb;
                        r_wready <= 1'b0;
                    end
                    if (w_aw_have && w_w_have) begin
                        if (f_in_window(w_awaddr_cur)) begin
                            r_wstate   <= W_REQ;
                            r_wr_valid <= 1'b1;
                            r_wcnt     <= '0;
                        end else begin
                            r_wstate <= W_RESP;
                            r_bvalid <= 1'b1;
                            r_bresp  <= RESP_DECERR;
                        end
                    end
                end
                W_REQ: begin
                    r_wcnt <= r_wcnt + 1'b1;
                    if (i_wr_ready) begin
                        r_wstate   <= W_RESP;
                        r_wr_valid <= 1'b0;
                        r_bvalid   <= 1'b1;
                        r_bresp    <= i_wr_resp;
                    end else if (r_wcnt == CNT_LAST) begin
                        r_wstate   <= W_RESP;
                        r_wr_valid <= 1'b0;
                        r_bvalid   <= 1'b1;
                        r_bresp    <= RESP_SLVERR;
                    end
                end
                W_RESP: begin
                    if (i_s_bready) begin
                        r_wstate  <= W_COLLECT;
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                    end
                end
                default: r_wstate <= W_COLLECT;
            endcase
        end
    end

    // Read path: accept AR, issue backend request, return R response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rstate   <= R_IDLE;
            r_arready  <= 1'b1;
            r_rvalid   <= 1'b0;
            r_rresp    <= 2'b00;
            r_rdata    <= '0;
            r_rd_valid <= 1'b0;
            r_araddr   <= '0;
            r_rcnt     <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (i_s_arvalid) begin
                        r_araddr  <= i_s_araddr;
                        r_arready <= 1'b0;
                        if (f_in_window(i_s_araddr)) begin
                            r_rstate   <= R_REQ;
                            r_rd_valid <= 1'b1;
                            r_rcnt     <= '0;
                        end else begin
                            r_rstate <= R_RESP;
                            r_rvalid <= 1'b1;
                            r_rresp  <= RESP_DECERR;
                            r_rdata  <= '0;
                        end
                    end
                end
                R_REQ: begin
                    r_rcnt <= r_rcnt + 1'b1;
                    if (i_rd_ready) begin
                        r_rstate   <= R_RESP;
                        r_rd_valid <= 1'b0;
                        r_rvalid   <= 1'b1;
                        r_rresp    <= i_rd_resp;
                        r_rdata    <= i_rd_data;
                    end else if (r_rcnt == CNT_LAST) begin
                        r_rstate   <= R_RESP;
                        r_rd_valid <= 1'b0;
                        r_rvalid   <= 1'b1;
                        r_rresp    <= RESP_SLVERR;
                        r_rdata    <= '0;
                    end
                end
                R_RESP: begin
                    if (i_s_rready) begin
                        r_rstate  <= R_IDLE;
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    assign o_s_awready = r_awready;
    assign o_s_wready  = r_wready;
    assign o_s_bvalid  = r_bvalid;
    assign o_s_bresp   = r_bresp;
    assign o_wr_valid  = r_wr_valid;
    assign o_wr_addr   = r_awaddr & ALIGN_MASK;
    assign o_wr_data   = r_wdata;
    assign o_wr_strb   = r_wstrb;
    assign o_s_arready = r_arready;
    assign o_s_rvalid  = r_rvalid;
    assign o_s_rresp   = r_rresp;
    assign o_s_rdata   = r_rdata;
    assign o_rd_valid  = r_rd_valid;
    assign o_rd_addr   = r_araddr & ALIGN_MASK;

endmodule
